// File: rtl/lut_ram_init_if.sv
// Bus bundle for lut_ram_init: one read port, one write port and the ready flag.
// The memory owns the slave modport; the requester owns the master modport.
interface lut_ram_init_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 5
);
  // rd_en/wr_en count only on an edge where ready is already high. Each read
  // taken on such an edge yields exactly one rd_valid pulse, in request order.
  // rd_data is meaningful only during that pulse and holds its value otherwise.
  logic             ready;
  logic             rd_en;
  logic [AW-1:0]    rd_adrs;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             wr_en;
  logic [AW-1:0]    wr_adrs;
  logic [WIDTH-1:0] wr_data;

  modport master (
    input  ready, rd_data, rd_valid,
    output rd_en, rd_adrs, wr_en, wr_adrs, wr_data
  );

  modport slave (
    output ready, rd_data, rd_valid,
    input  rd_en, rd_adrs, wr_en, wr_adrs, wr_data
  );
endinterface

// File: rtl/lut_ram_init.sv
// Run-time writable lookup table. After every reset a sequencer fills the
// whole array with a defined pattern, because the reset cannot clear storage.
module lut_ram_init #(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 32,
  parameter int               AW         = $clog2(DEPTH),
  parameter int               INIT_MODE  = 0,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0,
  parameter int               OUT_REG    = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  lut_ram_init_if.slave     bus,
  output logic              dbg_state
);
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  localparam int            AWP    = AW + 1;
  localparam logic [AW:0]   DEPTH_W = AWP'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t        state_q;
  logic [AW-1:0] cnt_q;
  logic          ready_q;

  // The fill counter stops on the last entry; ready rises on the same edge
  // that writes it, so the next request edge already sees ready high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (cnt_q == LAST) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_INIT;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  logic             run;
  logic             wr_ok;
  logic             rd_ok;
  logic             rd_in_range;
  logic [WIDTH-1:0] fill_val;
  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign run         = (state_q == ST_RUN);
  assign wr_ok       = run && bus.wr_en && ({1'b0, bus.wr_adrs} < DEPTH_W);
  assign rd_ok       = run && bus.rd_en;
  assign rd_in_range = ({1'b0, bus.rd_adrs} < DEPTH_W);

  always_comb begin
    fill_val = '0;
    if (INIT_MODE == 1) begin
      fill_val = WIDTH'(cnt_q);
    end else if (INIT_MODE == 2) begin
      fill_val = INIT_VALUE;
    end
  end

  // INIT owns the write port; in RUN only in-range writes reach the array.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = cnt_q;
    mem_wd = fill_val;
    if (!run) begin
      mem_we = 1'b1;
    end else if (wr_ok) begin
      mem_we = 1'b1;
      mem_wa = bus.wr_adrs;
      mem_wd = bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  logic             rd_valid1_q, rd_valid1_d;
  logic [WIDTH-1:0] rd_data1_q, rd_data1_d;

  // Sampling mem_q before this edge's write lands gives read-before-write.
  always_comb begin
    rd_valid1_d = rd_ok;
    rd_data1_d  = rd_data1_q;
    if (rd_ok) begin
      rd_data1_d = rd_in_range ? mem_q[bus.rd_adrs] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid1_q <= 1'b0;
      rd_data1_q  <= '0;
    end else begin
      rd_valid1_q <= rd_valid1_d;
      rd_data1_q  <= rd_data1_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic             rd_valid2_q, rd_valid2_d;
    logic [WIDTH-1:0] rd_data2_q, rd_data2_d;

    always_comb begin
      rd_valid2_d = rd_valid1_q;
      rd_data2_d  = rd_valid1_q ? rd_data1_q : rd_data2_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_valid2_q <= 1'b0;
        rd_data2_q  <= '0;
      end else begin
        rd_valid2_q <= rd_valid2_d;
        rd_data2_q  <= rd_data2_d;
      end
    end

    assign bus.rd_valid = rd_valid2_q;
    assign bus.rd_data  = rd_data2_q;
  end else begin : g_no_out_reg
    assign bus.rd_valid = rd_valid1_q;
    assign bus.rd_data  = rd_data1_q;
  end

  assign bus.ready = ready_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_lut_ram_init.sv
// Bench for lut_ram_init: three configurations share one clock and reset;
// drivers push expected data and arrival cycle, per-instance monitors pop.
module tb_lut_ram_init;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic dbg_a, dbg_b, dbg_c;

  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  logic [7:0] exp_q_c[$];
  int         cyc_q_a[$];
  int         cyc_q_b[$];
  int         cyc_q_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lut_ram_init_if #(.WIDTH(8), .AW(5)) bus_a ();
  lut_ram_init_if #(.WIDTH(8), .AW(5)) bus_b ();
  lut_ram_init_if #(.WIDTH(8), .AW(5)) bus_c ();

  lut_ram_init #(.WIDTH(8), .DEPTH(32), .INIT_MODE(1), .INIT_VALUE(8'h00), .OUT_REG(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .dbg_state(dbg_a)
  );
  lut_ram_init #(.WIDTH(8), .DEPTH(20), .INIT_MODE(2), .INIT_VALUE(8'h5A), .OUT_REG(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .dbg_state(dbg_b)
  );
  lut_ram_init #(.WIDTH(8), .DEPTH(32), .INIT_MODE(1), .INIT_VALUE(8'h00), .OUT_REG(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(bus_c), .dbg_state(dbg_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every rd_valid pulse must match the head of its queue in data and cycle.
  always @(negedge clk) begin : mon_a
    logic [7:0] d;
    int c;
    if (bus_a.rd_valid !== 1'b0) begin
      if (exp_q_a.size() == 0) check("a_unexpected_valid", 32'(bus_a.rd_valid), 32'd0);
      else begin
        d = exp_q_a.pop_front();
        c = cyc_q_a.pop_front();
        check("a_rd_data", 32'(bus_a.rd_data), 32'(d));
        check("a_rd_cycle", 32'(cyc), 32'(c));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [7:0] d;
    int c;
    if (bus_b.rd_valid !== 1'b0) begin
      if (exp_q_b.size() == 0) check("b_unexpected_valid", 32'(bus_b.rd_valid), 32'd0);
      else begin
        d = exp_q_b.pop_front();
        c = cyc_q_b.pop_front();
        check("b_rd_data", 32'(bus_b.rd_data), 32'(d));
        check("b_rd_cycle", 32'(cyc), 32'(c));
      end
    end
  end

  always @(negedge clk) begin : mon_c
    logic [7:0] d;
    int c;
    if (bus_c.rd_valid !== 1'b0) begin
      if (exp_q_c.size() == 0) check("c_unexpected_valid", 32'(bus_c.rd_valid), 32'd0);
      else begin
        d = exp_q_c.pop_front();
        c = cyc_q_c.pop_front();
        check("c_rd_data", 32'(bus_c.rd_data), 32'(d));
        check("c_rd_cycle", 32'(cyc), 32'(c));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request drivers: the read is sampled on edge cyc+1 and shows up OUT_REG edges later.
  task automatic set_rd_a(input logic [4:0] a, input logic [7:0] e);
    bus_a.rd_en = 1'b1;
    bus_a.rd_adrs = a;
    exp_q_a.push_back(e);
    cyc_q_a.push_back(cyc + 1);
  endtask

  task automatic set_rd_b(input logic [4:0] a, input logic [7:0] e);
    bus_b.rd_en = 1'b1;
    bus_b.rd_adrs = a;
    exp_q_b.push_back(e);
    cyc_q_b.push_back(cyc + 1);
  endtask

  task automatic set_rd_c(input logic [4:0] a, input logic [7:0] e);
    bus_c.rd_en = 1'b1;
    bus_c.rd_adrs = a;
    exp_q_c.push_back(e);
    cyc_q_c.push_back(cyc + 2);
  endtask

  task automatic set_wr_a(input logic [4:0] a, input logic [7:0] d);
    bus_a.wr_en = 1'b1;
    bus_a.wr_adrs = a;
    bus_a.wr_data = d;
  endtask

  task automatic set_wr_b(input logic [4:0] a, input logic [7:0] d);
    bus_b.wr_en = 1'b1;
    bus_b.wr_adrs = a;
    bus_b.wr_data = d;
  endtask

  task automatic idle_all();
    bus_a.rd_en = 1'b0; bus_a.wr_en = 1'b0;
    bus_b.rd_en = 1'b0; bus_b.wr_en = 1'b0;
    bus_c.rd_en = 1'b0; bus_c.wr_en = 1'b0;
  endtask

  initial begin
    bus_a.rd_adrs = '0; bus_a.wr_adrs = '0; bus_a.wr_data = '0;
    bus_b.rd_adrs = '0; bus_b.wr_adrs = '0; bus_b.wr_data = '0;
    bus_c.rd_adrs = '0; bus_c.wr_adrs = '0; bus_c.wr_data = '0;
    idle_all();

    repeat (3) step();
    check("reset_ready_a", 32'(bus_a.ready), 32'd0);
    check("reset_valid_a", 32'(bus_a.rd_valid), 32'd0);
    check("reset_data_a", 32'(bus_a.rd_data), 32'd0);
    check("reset_state_a", 32'(dbg_a), 32'd0);
    check("reset_ready_c", 32'(bus_c.ready), 32'd0);
    check("reset_data_c", 32'(bus_c.rd_data), 32'd0);

    // INIT: B requests and A writes must both be ignored; ready timing is exact.
    reset_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      bus_b.rd_en = (i <= 20);
      bus_b.rd_adrs = 5'd3;
      bus_a.wr_en = (i >= 25);
      bus_a.wr_adrs = 5'd0;
      bus_a.wr_data = 8'hEE;
      @(posedge clk);
      @(negedge clk);
      check("a_ready_init", 32'(bus_a.ready), 32'(i == 32));
      check("b_ready_init", 32'(bus_b.ready), 32'(i >= 20));
      check("c_ready_init", 32'(bus_c.ready), 32'(i == 32));
    end
    idle_all();
    check("run_state_a", 32'(dbg_a), 32'd1);

    for (int i = 0; i < 32; i++) begin
      set_rd_a(5'(i), 8'(i));
      step();
    end
    idle_all();
    repeat (2) step();

    set_wr_a(5'd7, 8'hA5);
    step();
    idle_all();
    set_rd_a(5'd7, 8'hA5);
    step();
    set_rd_a(5'd8, 8'h08);
    step();
    idle_all();
    repeat (3) step();
    check("a_rd_data_hold", 32'(bus_a.rd_data), 32'h08);
    check("a_valid_idle", 32'(bus_a.rd_valid), 32'd0);

    set_wr_a(5'd3, 8'h3C);
    set_rd_a(5'd3, 8'h03);
    step();
    idle_all();
    set_rd_a(5'd3, 8'h3C);
    step();
    idle_all();
    repeat (2) step();

    set_wr_b(5'd25, 8'hFF);
    step();
    idle_all();
    set_rd_b(5'd25, 8'h00);
    step();
    set_rd_b(5'd5, 8'h5A);
    step();
    set_rd_b(5'd9, 8'h5A);
    step();
    set_rd_b(5'd19, 8'h5A);
    step();
    idle_all();
    repeat (2) step();

    // Read of address 7 is taken, then reset lands before its pulse is sampled.
    bus_a.rd_en = 1'b1;
    bus_a.rd_adrs = 5'd7;
    step();
    reset_n = 1'b0;
    bus_a.rd_en = 1'b0;
    #1;
    check("midrst_ready_a", 32'(bus_a.ready), 32'd0);
    check("midrst_valid_a", 32'(bus_a.rd_valid), 32'd0);
    check("midrst_data_a", 32'(bus_a.rd_data), 32'd0);
    check("midrst_state_a", 32'(dbg_a), 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (31) step();
    check("reinit_ready_a_early", 32'(bus_a.ready), 32'd0);
    step();
    check("reinit_ready_a", 32'(bus_a.ready), 32'd1);
    set_rd_a(5'd7, 8'h07);
    step();
    idle_all();
    repeat (2) step();

    for (int i = 1; i <= 4; i++) begin
      set_rd_c(5'(i), 8'(i));
      step();
    end
    idle_all();
    repeat (4) step();
    check("c_rd_data_hold", 32'(bus_c.rd_data), 32'h04);

    repeat (2) step();
    check("a_queue_empty", 32'(exp_q_a.size()), 32'd0);
    check("b_queue_empty", 32'(exp_q_b.size()), 32'd0);
    check("c_queue_empty", 32'(exp_q_c.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lut_ram_init.md
# lut_ram_init

Parametrised lookup-table memory with a synchronous read port, a write port and a built-in initialisation sequencer. It replaces fixed-size combinational ROM tables wherever the mesh needs a table that is both configurable in size and updatable at run time, such as routing tables and per-port configuration words. After every reset it fills itself with a defined pattern, because an asynchronous reset cannot clear the storage array.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 32, number of entries (≥2; need not be a power of 2)
- AW, $clog2(DEPTH), address width; derived, never overridden
- INIT_MODE, 0, fill pattern: 0 = all zero; 1 = entry index, zero-extended or truncated to WIDTH; 2 = INIT_VALUE in every entry
- INIT_VALUE, '0, WIDTH-bit constant used when INIT_MODE = 2
- OUT_REG, 0, 1 adds an output register stage to the read path
- clk  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- ready  out  1  high once initialisation completes; low during reset and INIT
- rd_en  in  1  read request, sampled on the rising edge
- rd_adrs  in  AW  read address
- rd_data  out  WIDTH  read data; meaningful only while rd_valid is high
- rd_valid  out  1  one-cycle pulse per accepted read
- wr_en  in  1  write request, sampled on the rising edge
- wr_adrs  in  AW  write address
- wr_data  in  WIDTH  write data

## Operation
- FSM states: INIT and RUN.
- While reset_n is low, the FSM is in INIT with the fill counter at 0.
- INIT: writes the fill pattern to entry cnt on every cycle, for cnt = 0 … DEPTH-1. The transition to RUN occurs on the edge that performs the final write.
- rd_en and wr_en are ignored in INIT: no write takes place and no rd_valid is issued.
- RUN: one read and one write may be accepted per cycle, independently.
- Read/write collision (same address, same edge): the read returns the old contents (read-before-write). The new value is visible to reads starting the following edge.
- Out-of-range address (≥ DEPTH, possible when DEPTH is not a power of 2):
  - write: dropped, with no aliasing onto a legal entry;
  - read: accepted, returns all zeros, and rd_valid is asserted as normal.
- rd_data holds its last value while rd_valid is low.
- Reset mid-operation:
  - ready, rd_valid and the entire read pipeline clear immediately;
  - any in-flight read is lost;
  - on release, INIT reruns and overwrites all entries, including run-time writes.

## Timing
- Reset values: ready = 0, rd_valid = 0, rd_data = 0, FSM = INIT, counter = 0.
- Initialisation:
  - the first rising edge with reset_n high writes entry 0;
  - ready goes high after exactly DEPTH rising edges.
- Read latency:
  - rd_en sampled at edge k gives rd_data/rd_valid after edge k+1-1, i.e. valid in the cycle following edge k, when OUT_REG = 0;
  - with OUT_REG = 1, they are valid after edge k+1.
- Throughput: one read per cycle, fully pipelined. Back-to-back reads produce back-to-back rd_valid pulses in request order.
- Writes take effect at the sampling edge: a read sampled on the next edge sees the new data.
- ready is registered. The first request that is honoured is one sampled on an edge where ready is already high.

## Test plan
- Init and index fill (DEPTH = 32, WIDTH = 8, INIT_MODE = 1, OUT_REG = 0):
  - release reset; ready rises after exactly 32 edges;
  - read addresses 0 … 31 back-to-back; the bench requires 32 consecutive rd_valid pulses with data 0x00 … 0x1F and latency 1.
- Write/readback:
  - write 0xA5 to address 7; read address 7 on the next edge; expect 0xA5;
  - read address 8; expect 0x08.
- Collision:
  - in the same cycle, write 0x3C to address 3 and read address 3; the read returns 0x03;
  - the following read of address 3 returns 0x3C.
- Non-power-of-2 depth (DEPTH = 20, INIT_MODE = 2, INIT_VALUE = 0x5A):
  - write 0xFF to address 25; then read address 25, which returns 0x00 with rd_valid high;
  - read address 5, which returns 0x5A (no aliasing);
  - during INIT, rd_en pulses produce no rd_valid.
- Reset mid-stream:
  - after writing 0xA5 to address 7, drop reset_n while a read is in flight; ready and rd_valid go low immediately and no stale pulse appears;
  - after release and the 32-edge INIT (INIT_MODE = 1), address 7 reads 0x07.
- OUT_REG = 1: 4 back-to-back reads of addresses 1, 2, 3, 4 give rd_valid pulses on the 2nd … 5th cycles, with data 0x01 … 0x04.
